fifo_uart_tx: RTL



---
 rtl/fifo_uart_pkg.sv | 22 ++
 rtl/fifo_uart_tx_baud_tick_gen.sv | 34 +++
 rtl/fifo_uart_tx.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fifo_uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_uart_pkg : shared constants and state encoding for fifo_uart_tx |
// | PARITY is only reachable when FIFO_UART_TX_PARITY_EN is defined.     |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
package fifo_uart_pkg;

  localparam int   DATA_W      = 8;
  localparam logic TX_IDLE_LVL = 1'b1;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] FETCH  = 3'd1;
  localparam logic [STATE_W-1:0] LOAD   = 3'd2;
  localparam logic [STATE_W-1:0] START  = 3'd3;
  localparam logic [STATE_W-1:0] DATA   = 3'd4;
  localparam logic [STATE_W-1:0] PARITY = 3'd5;
  localparam logic [STATE_W-1:0] STOP   = 3'd6;

endpackage
`default_nettype wire

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | baud_tick_gen : free-running bit-period counter with sync clear,    |
// | one-cycle tick on terminal count.  Revision: 1.0                    |
// +--------------------------------------------------------------------+
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] c_TERMINAL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_ONE;
    end
  end

  assign tick = (r_cnt == c_TERMINAL);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_uart_tx : pops bytes from the sync FIFO and sends 8N1 frames.  |
// | Define FIFO_UART_TX_PARITY_EN to add an even-parity bit.            |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_read_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  import fifo_uart_pkg::*;

  localparam logic [2:0] c_LAST_BIT = 3'(DATA_W - 1);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;
  logic [DATA_W-1:0]  r_shift;
  logic [DATA_W-1:0]  w_shift_next;
  logic [2:0]         r_bit_cnt;
  logic [2:0]         w_bit_cnt_next;
  logic               r_tx;
  logic               w_tx_next;
  logic               w_tick;
  logic               w_clear;

  // Counter restarts on every state change so each state gets full bit periods.
  assign w_clear = (w_next_state != r_state);

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .tick  (w_tick)
  );

`ifdef FIFO_UART_TX_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_parity <= 1'b0;
    end else if (r_state == LOAD) begin
      r_parity <= ^fifo_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_tx      <= TX_IDLE_LVL;
    end else begin
      r_state   <= w_next_state;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_tx      <= w_tx_next;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    case (r_state)
      IDLE:  if (!fifo_empty) w_next_state = FETCH;
      FETCH: w_next_state = LOAD;
      LOAD: begin
        w_shift_next = fifo_data;
        w_next_state = START;
      end
      START: if (w_tick) w_next_state = DATA;
      DATA: begin
        if (w_tick) begin
          w_shift_next   = r_shift >> 1;
          w_bit_cnt_next = r_bit_cnt + 3'd1;
          if (r_bit_cnt == c_LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
            w_next_state = PARITY;
`else
            w_next_state = STOP;
`endif
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: if (w_tick) w_next_state = STOP;
`endif
      STOP:  if (w_tick) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // tx is registered from the next-state view so the line tracks r_state exactly.
  always_comb begin
    fifo_read_en = (r_state == FETCH);
    busy         = (r_state != IDLE);
    tx_done      = (r_state == STOP) && w_tick;
    case (w_next_state)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  w_tx_next = r_parity;
`endif
      default: w_tx_next = TX_IDLE_LVL;
    endcase
  end

  assign tx = r_tx;

endmodule
`default_nettype wire
